// File: rtl/s9234_scan_ctrl.sv
// s9234_scan_ctrl: scan test sequencer for the scan-inserted s9234 wrapper.
// It buffers one pattern from a valid/ready stream, shifts it in while
// unloading the previous response, captures, and flushes the last response.
// Optional MISR compaction of the response stream: define S9234_SCAN_CTRL_MISR_EN.
module s9234_scan_ctrl #(
  parameter int CHAIN_LEN = 211,
  parameter int CW        = $clog2(CHAIN_LEN + 1)
) (
  input  logic        CK,
  input  logic        RSTn,
  input  logic        start,
  input  logic [15:0] num_patterns,
  input  logic        si_valid,
  input  logic        si_data,
  output logic        si_ready,
  output logic        scan_en,
  output logic        scan_in,
  input  logic        scan_out,
  output logic        so_valid,
  output logic        so_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CAPTURE,
    ST_FLUSH
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_bitcnt;
  logic [15:0]          r_patcnt;
  logic [15:0]          r_num;
  logic [CHAIN_LEN-1:0] r_buf;
  logic                 r_scan_en;
  logic                 r_scan_in;
  logic                 r_si_ready;
  logic                 r_so_valid;
  logic                 r_so_data;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_beat;
  logic                 w_bit_last;
  logic [CHAIN_LEN-1:0] w_buf_load;
  logic [15:0]          w_patcnt_inc;

  assign w_beat       = si_valid & r_si_ready;
  assign w_bit_last   = (r_bitcnt == CW'(CHAIN_LEN - 1));
  // New beats enter at the top, so the first accepted bit ends up at index 0.
  assign w_buf_load   = {si_data, r_buf[CHAIN_LEN-1:1]};
  assign w_patcnt_inc = r_patcnt + 16'd1;

  // Sequencer FSM with registered scan/stream/status outputs.
  always_ff @(posedge CK) begin
    if (!RSTn) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_patcnt   <= '0;
      r_num      <= '0;
      r_scan_en  <= 1'b0;
      r_scan_in  <= 1'b0;
      r_si_ready <= 1'b0;
      r_so_valid <= 1'b0;
      r_so_data  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      // Response bit is scan_out taken at the same edge that shifts the chain;
      // the first pattern's unload is chain garbage, not a response.
      r_so_valid <= ((r_state == ST_SHIFT) && (r_patcnt != 16'd0)) ||
                    (r_state == ST_FLUSH);
      r_so_data  <= scan_out;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (num_patterns == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
              r_num      <= num_patterns;
              r_patcnt   <= '0;
              r_bitcnt   <= '0;
              r_si_ready <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_beat) begin
            if (w_bit_last) begin
              r_state    <= ST_SHIFT;
              r_bitcnt   <= '0;
              r_si_ready <= 1'b0;
              r_scan_en  <= 1'b1;
              r_scan_in  <= w_buf_load[0];
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (w_bit_last) begin
            r_state   <= ST_CAPTURE;
            r_bitcnt  <= '0;
            r_scan_en <= 1'b0;
            r_scan_in <= 1'b0;
          end else begin
            r_bitcnt  <= r_bitcnt + 1'b1;
            r_scan_in <= r_buf[0];
          end
        end
        ST_CAPTURE: begin
          r_patcnt <= w_patcnt_inc;
          if (w_patcnt_inc == r_num) begin
            r_state   <= ST_FLUSH;
            r_scan_en <= 1'b1;
          end else begin
            r_state    <= ST_LOAD;
            r_si_ready <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (w_bit_last) begin
            r_state   <= ST_IDLE;
            r_bitcnt  <= '0;
            r_scan_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_bitcnt <= r_bitcnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pattern buffer: fill in acceptance order, then drain one bit per shift.
  // On the last beat bit 0 goes straight to scan_in, so the buffer is stored
  // pre-advanced by one and r_buf[0] always holds the next bit to present.
  always_ff @(posedge CK) begin
    if ((r_state == ST_LOAD) && w_beat) begin
      r_buf <= w_bit_last ? {1'b0, w_buf_load[CHAIN_LEN-1:1]} : w_buf_load;
    end else if (r_state == ST_SHIFT) begin
      r_buf <= {1'b0, r_buf[CHAIN_LEN-1:1]};
    end
  end

`ifdef S9234_SCAN_CTRL_MISR_EN
  logic [15:0] r_sig;
  logic        w_fb;

  assign w_fb = r_sig[15] ^ r_so_data;

  // CRC-16/CCITT style MISR over every presented response bit.
  always_ff @(posedge CK) begin
    if (!RSTn) begin
      r_sig <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_sig <= '0;
    end else if (r_so_valid) begin
      r_sig <= {r_sig[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
    end
  end

  assign signature = r_sig;
`else
  assign signature = 16'h0000;
`endif

  assign si_ready = r_si_ready;
  assign scan_en  = r_scan_en;
  assign scan_in  = r_scan_in;
  assign so_valid = r_so_valid;
  assign so_data  = r_so_data;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_s9234_scan_ctrl.sv
// Testbench for s9234_scan_ctrl with CHAIN_LEN=8 and an echoing wrapper chain.
module tb_s9234_scan_ctrl;
  localparam int CL = 8;

  logic        CK = 1'b0;
  logic        RSTn;
  logic        start;
  logic [15:0] num_patterns;
  logic        si_valid;
  logic        si_data;
  logic        si_ready;
  logic        scan_en;
  logic        scan_in;
  logic        scan_out;
  logic        so_valid;
  logic        so_data;
  logic        busy;
  logic        done;
  logic [15:0] signature;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  always #5 CK = ~CK;

  s9234_scan_ctrl #(.CHAIN_LEN(CL)) dut (
    .CK(CK), .RSTn(RSTn), .start(start), .num_patterns(num_patterns),
    .si_valid(si_valid), .si_data(si_data), .si_ready(si_ready),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
    .so_valid(so_valid), .so_data(so_data), .busy(busy), .done(done),
    .signature(signature)
  );

  // Wrapper chain: shifts when scan_en=1, holds (echoes) on capture.
  logic [CL-1:0] chain = '0;
  always @(posedge CK) if (scan_en === 1'b1) chain <= {chain[CL-2:0], scan_in};
  assign scan_out = chain[CL-1];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic b);
`ifdef S9234_SCAN_CTRL_MISR_EN
    logic fb;
    fb = s[15] ^ b;
    return {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
`else
    return 16'h0000;
`endif
  endfunction

  // Reference: phase 0 idle, 1 load, 2 shift, 3 capture, 4 flush.
  int          m_ph = 0;
  int          m_cnt = 0;
  int          m_pat = 0;
  int          m_num = 0;
  logic [CL-1:0] m_bits = '0;
  bit          q[$];
  logic        e_sov = 0;
  logic        e_sod = 0;
  logic        e_done = 0;
  logic [15:0] e_sig = 0;
  bit          sod_known = 1;

  always @(posedge CK) begin
    bit nsov;
    bit nsod;
    if (!RSTn) begin
      m_ph = 0; m_cnt = 0; m_pat = 0;
      q.delete();
      e_sov = 0; e_sod = 0; e_done = 0; e_sig = 0; sod_known = 1;
    end else begin
      nsov = ((m_ph == 2) && (m_pat > 0)) || (m_ph == 4);
      nsod = 0;
      if (nsov && q.size() > 0) nsod = q.pop_front();
      if (m_ph == 0 && start) e_sig = 16'h0000;
      else if (e_sov) e_sig = misr_step(e_sig, e_sod);
      e_done = 0;
      case (m_ph)
        0: if (start) begin
             if (num_patterns == 16'd0) e_done = 1;
             else begin m_ph = 1; m_num = int'(num_patterns); m_pat = 0; m_cnt = 0; end
           end
        1: if (si_valid) begin
             m_bits[m_cnt] = si_data;
             q.push_back(si_data);
             m_cnt++;
             if (m_cnt == CL) begin m_ph = 2; m_cnt = 0; end
           end
        2: begin m_cnt++; if (m_cnt == CL) begin m_ph = 3; m_cnt = 0; end end
        3: begin m_pat++; m_ph = (m_pat < m_num) ? 1 : 4; end
        default: begin
          m_cnt++;
          if (m_cnt == CL) begin m_ph = 0; m_cnt = 0; e_done = 1; end
        end
      endcase
      e_sov = nsov; e_sod = nsod; sod_known = nsov;
    end
  end

  bit rec_si[$];
  bit rec_so[$];
  int n_sov = 0;

  always @(negedge CK) begin
    if (cmp_en) begin
      chk("busy", {15'd0, busy}, {15'd0, m_ph != 0});
      chk("si_ready", {15'd0, si_ready}, {15'd0, m_ph == 1});
      chk("scan_en", {15'd0, scan_en}, {15'd0, (m_ph == 2) || (m_ph == 4)});
      chk("scan_in", {15'd0, scan_in}, {15'd0, (m_ph == 2) ? m_bits[m_cnt] : 1'b0});
      chk("done", {15'd0, done}, {15'd0, e_done});
      chk("so_valid", {15'd0, so_valid}, {15'd0, e_sov});
      if (sod_known) chk("so_data", {15'd0, so_data}, {15'd0, e_sod});
      chk("signature", signature, e_sig);
      if (scan_en === 1'b1) rec_si.push_back(scan_in);
      if (so_valid === 1'b1) begin n_sov++; rec_so.push_back(so_data); end
    end
  end

  task automatic tick();
    @(posedge CK); #2;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1; num_patterns = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int maxgap);
    int g;
    int t;
    bit acc;
    g = $urandom_range(maxgap, 0);
    si_valid = 1'b0;
    repeat (g) tick();
    si_valid = 1'b1; si_data = b;
    acc = 0; t = 0;
    while (!acc && t < 1000) begin
      acc = si_ready;
      tick();
      t++;
    end
    si_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout at %0t: got no beat accepted expected accept", $time);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 3000) begin tick(); t++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout at %0t: got done=%b expected 1", $time, done);
    end
  endtask

  task automatic clear_rec();
    rec_si.delete(); rec_so.delete(); n_sov = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog at %0t: got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit           sent[$];
    logic [7:0]   v;
    logic [7:0]   pat1;
    int           nmis;
    int           n;
    logic         b;
    RSTn = 1'b0; start = 1'b1; num_patterns = 16'd5; si_valid = 1'b0; si_data = 1'b0;
    @(posedge CK); #2;
    cmp_en = 1;
    repeat (2) tick();
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_scan_en", {15'd0, scan_en}, 16'd0);
    chk("rst_sig", signature, 16'h0000);
    RSTn = 1'b1; start = 1'b0;
    tick();
    chk("post_rst_busy", {15'd0, busy}, 16'd0);

    // Zero patterns
    do_start(16'd0);
    chk("zero_done", {15'd0, done}, 16'd1);
    chk("zero_busy", {15'd0, busy}, 16'd0);
    tick();
    chk("zero_done_clr", {15'd0, done}, 16'd0);

    // One pattern, fixed bits with random gaps
    pat1 = 8'b10110010;
    clear_rec();
    do_start(16'd1);
    for (int i = 0; i < CL; i++) send_bit(pat1[7-i], 3);
    wait_done();
    tick();
    for (int i = 0; i < 8; i++) v[7-i] = (i < rec_si.size()) ? rec_si[i] : 1'b0;
    chk("p1_scan_in_seq", {8'd0, v}, 16'h00B2);
    chk("p1_scan_en_cycles", 16'(rec_si.size()), 16'd16);
    chk("p1_so_count", 16'(n_sov), 16'd8);

    // Three patterns: responses echo each loaded pattern
    clear_rec(); sent.delete();
    do_start(16'd3);
    for (int i = 0; i < 3*CL; i++) begin
      b = 1'($urandom_range(1, 0));
      sent.push_back(b);
      send_bit(b, 2);
    end
    wait_done();
    tick();
    chk("p3_so_count", 16'(n_sov), 16'd24);
    nmis = 0;
    for (int i = 0; i < 24; i++)
      if (i >= rec_so.size() || rec_so[i] != sent[i]) nmis++;
    chk("p3_so_stream", 16'(nmis), 16'd0);

    // Ignored starts while busy, then reset in 4th SHIFT cycle
    do_start(16'd2);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(1, 0)), 1);
    start = 1'b1; num_patterns = 16'd7; tick(); start = 1'b0;
    chk("busy_start_ign", {15'd0, busy}, 16'd1);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(1, 0)), 1);
    repeat (3) tick();
    chk("mid_scan_en", {15'd0, scan_en}, 16'd1);
    RSTn = 1'b0;
    tick();
    chk("mid_rst_scan_en", {15'd0, scan_en}, 16'd0);
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);
    RSTn = 1'b1;
    tick();
    clear_rec();
    do_start(16'd2);
    for (int i = 0; i < 2*CL; i++) send_bit(1'($urandom_range(1, 0)), 2);
    wait_done();
    tick();
    chk("clean_so_count", 16'(n_sov), 16'd16);

    // MISR pins
    do_start(16'd1);
    for (int i = 0; i < CL; i++) send_bit((i == CL-1) ? 1'b1 : 1'b0, 2);
    wait_done();
    tick();
`ifdef S9234_SCAN_CTRL_MISR_EN
    chk("misr_one", signature, 16'h1021);
`else
    chk("misr_one", signature, 16'h0000);
`endif
    do_start(16'd1);
    for (int i = 0; i < CL; i++) send_bit(1'b0, 2);
    wait_done();
    tick();
    chk("misr_zero", signature, 16'h0000);

    // Random runs
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(3, 1);
      clear_rec();
      do_start(16'(n));
      for (int i = 0; i < n*CL; i++) send_bit(1'($urandom_range(1, 0)), 3);
      wait_done();
      tick();
      chk("rand_so_count", 16'(n_sov), 16'(n*CL));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
